fetch_stage: RTL

//  IF stage of the 5-stage MIPS pipeline, directly upstream of decode_stage.

---
 rtl/fetch_stage.sv | 81 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC and the IF/ID register,
// handling load-use stall, branch/jump redirect, flush and external PC load.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 SYS_clk,
    input  logic                 SYS_reset,
    input  logic                 SYS_load,
    input  logic [7:0]           SYS_pc_val,
    input  logic                 F_stall,
    input  logic                 F_flush,
    input  logic                 F_redirect,
    input  logic [31:0]          F_redirect_target,
    output logic [31:0]          IMEM_PC,
    input  logic [31:0]          IMEM_instruction,
    output logic [31:0]          D_instruction,
    output logic [31:0]          D_pc_plus4,
    output logic                 D_valid,
    output logic                 F_misalign_err,
    output logic [CNT_WIDTH-1:0] F_fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        misalign_next;
    logic        squash;
    logic        ifid_load;

    assign IMEM_PC  = pc;
    assign pc_plus4 = pc + 32'd4;

    // Any control-flow change or flush squashes the wrong-path fetch, even under stall.
    assign squash    = SYS_load | F_redirect | F_flush;
    assign ifid_load = !squash && !F_stall;

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the if/else chain leaves it unassigned and infers a latch.
    always_comb begin
        pc_next       = pc_plus4;
        misalign_next = 1'b0;
        if (SYS_load) begin
            pc_next       = {24'b0, SYS_pc_val[7:2], 2'b00};
            misalign_next = (SYS_pc_val[1:0] != 2'b00);
        end else if (F_redirect) begin
            pc_next       = {F_redirect_target[31:2], 2'b00};
            misalign_next = (F_redirect_target[1:0] != 2'b00);
        end else if (F_stall) begin
            pc_next = pc;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order inside the block.
    always_ff @(negedge SYS_clk) begin
        if (SYS_reset) begin
            pc             <= RESET_PC;
            D_instruction  <= NOP_INSTR;
            D_pc_plus4     <= 32'd0;
            D_valid        <= 1'b0;
            F_misalign_err <= 1'b0;
            F_fetch_count  <= '0;
        end else begin
            pc             <= pc_next;
            F_misalign_err <= misalign_next;
            if (squash) begin
                D_instruction <= NOP_INSTR;
                D_pc_plus4    <= 32'd0;
                D_valid       <= 1'b0;
            end else if (ifid_load) begin
                D_instruction <= IMEM_instruction;
                D_pc_plus4    <= pc_plus4;
                D_valid       <= 1'b1;
                F_fetch_count <= F_fetch_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
